muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide engine with internal HI/LO result registers. Successor to the fixed-32-bit DIV/Multi pair and the separate HI/LO registers.
- Supports signed and unsigned multiply and divide through one start/done handshake. Flags divide-by-zero.
- Sits beside the ALU in the multicycle datapath. Operands come from the A/B registers; the control FSM waits on done before writing back HI/LO.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_signfix.sv | 10 +
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding and FSM states.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake plus operand and HI/LO result bundle for muldiv_unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negate, used for operand magnitudes and result signs.
module muldiv_signfix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);
    assign result = neg ? -value : value;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide with internal HI/LO result registers.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    muldiv_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_signed, op_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH:0]     rem_shift, trial;

    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .value  (bus.a),
        .neg    (op_signed & bus.a[WIDTH-1]),
        .result (a_mag)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .value  (bus.b),
        .neg    (op_signed & bus.b[WIDTH-1]),
        .result (b_mag)
    );

    muldiv_signfix #(.WIDTH(2 * WIDTH)) u_fix_prod (
        .value  (acc_q),
        .neg    (neg_res_q),
        .result (prod_fix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (acc_q[WIDTH-1:0]),
        .neg    (neg_res_q),
        .result (quo_fix)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc_q[2*WIDTH-1:WIDTH]),
        .neg    (neg_rem_q),
        .result (rem_fix)
    );

    // Divide keeps remainder in acc[2W-1:W] and quotient in acc[W-1:0]; divisor lives in mplier.
    assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial     = rem_shift - {1'b0, mplier_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    div0_d = 1'b0;
                    if (op_div && (bus.b == '0)) begin
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        is_div_d  = op_div;
                        neg_res_d = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_d = op_signed & bus.a[WIDTH-1];
                        count_d   = CNT_W'(WIDTH);
                        mplier_d  = b_mag;
                        state_d   = CALC;
                        if (op_div) begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            mcand_d = '0;
                        end else begin
                            acc_d   = '0;
                            mcand_d = {{WIDTH{1'b0}}, a_mag};
                        end
                    end
                end
            end

            CALC: begin
                count_d = count_q - CNT_W'(1);
                if (is_div_q) begin
                    if (!trial[WIDTH]) begin
                        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (count_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
`ifdef MULDIV_EARLY_OUT_EN
                if (!is_div_q && (mplier_d == '0)) begin
                    state_d = FIX;
                end
`endif
            end

            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                div0_d  = 1'b0;
                state_d = DONE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            // Pulse trails the DONE state by one cycle, when HI/LO/div0 are already registered.
            done_q    <= (state_q == DONE);
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q == CALC) || (state_q == FIX);
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
    localparam int unsigned W = 32;

    logic        clock = 1'b0;
    logic        reset;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi   = '0;
    logic [31:0] exp_lo   = '0;
    logic        exp_div0 = 1'b0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: updates the expected HI/LO/div0 state and returns latency in edges.
    task automatic predict(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int lat);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lat = W + 2;
        case (o)
            2'd0: begin
                p = sx * sy;
                exp_hi = p[63:32]; exp_lo = p[31:0]; exp_div0 = 1'b0;
            end
            2'd1: begin
                p = {32'd0, x} * {32'd0, y};
                exp_hi = p[63:32]; exp_lo = p[31:0]; exp_div0 = 1'b0;
            end
            2'd2: begin
                if (y == 0) begin
                    exp_div0 = 1'b1; lat = 1;
                end else begin
                    q = sx / sy; r = sx % sy;
                    exp_lo = q[31:0]; exp_hi = r[31:0]; exp_div0 = 1'b0;
                end
            end
            default: begin
                if (y == 0) begin
                    exp_div0 = 1'b1; lat = 1;
                end else begin
                    exp_lo = x / y; exp_hi = x % y; exp_div0 = 1'b0;
                end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (o < 2'd2) begin
            logic [31:0] mag;
            int          k;
            mag = (o == 2'd0 && y[31]) ? (32'd0 - y) : y;
            k = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
            lat = k + 2;
        end
`endif
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit poke);
        int lat, n;
        bit busy_ok, seen;
        predict(o, x, y, lat);
        @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clock);
        #1;
        // Scramble operands after acceptance; they must not affect the result.
        bus.start = 1'b0; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
        n = 0; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && n < 200) begin
            if (bus.busy !== (n < lat - 1)) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (poke) bus.start = (n == 3 || n == 4 || n == lat - 3);
                @(posedge clock);
                #1;
                n++;
            end
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(lat));
        check({tag, ".busy"}, 64'(busy_ok), 64'd1);
        check({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, ".div0"}, 64'(bus.div0), 64'(exp_div0));
        @(posedge clock);
        #1;
        check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x, y;
        int          sel;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.div0", 64'(bus.div0), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_zero", 2'd3, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op("multu_clr", 2'd1, 32'h0001_0003, 32'h0000_0101, 1'b0);
        run_op("multu_small", 2'd1, 32'h0000_0005, 32'h0000_0003, 1'b0);
        run_op("div_zero", 2'd2, 32'h8765_4321, 32'h0000_0000, 1'b0);
        run_op("multu_poke", 2'd1, 32'h0000_1234, 32'h0000_5678, 1'b1);
        run_op("divu_poke", 2'd3, 32'hDEAD_BEEF, 32'h0000_0013, 1'b1);

        for (int i = 0; i < 24; i++) begin
            o   = 2'($urandom_range(0, 3));
            x   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 4);
            y   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
                  (sel == 2) ? 32'hFFFF_FFFF : $urandom;
            run_op($sformatf("rand%0d", i), o, x, y, 1'($urandom_range(0, 1)));
        end

        // Leave nonzero HI/LO, then abort a multiply mid-CALC with an asynchronous reset.
        run_op("mult_pre", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'hCAFE_F00D; bus.b = 32'h0BAD_BEEF;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midreset.busy", 64'(bus.busy), 64'd0);
        check("midreset.done", 64'(bus.done), 64'd0);
        check("midreset.div0", 64'(bus.div0), 64'd0);
        check("midreset.hi", 64'(bus.hi), 64'd0);
        check("midreset.lo", 64'(bus.lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        run_op("post_reset", 2'd3, 32'h0000_0064, 32'h0000_0007, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
